// File: rtl/controle_vedacao.sv
// Capping-station controller: stopper stock keeping, per-bottle stop/request/cap/release sequence, capped-bottle count.
// Optional stopper-wait timeout built only when VEDACAO_TIMEOUT_EN is defined.
module controle_vedacao #(
  parameter int STOCK_W        = 8,
  parameter int STOCK_MAX      = 20,
  parameter int ADD_QTY        = 5,
  parameter int LOW_THRESH     = 5,
  parameter int CAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               garrafa_pos,
  input  logic               garrafa_cheia,
  input  logic               add_rolha,
  input  logic               rolha_det,
  output logic               estoque_ok,
  output logic               motor_esteira,
  output logic               pede_rolha,
  output logic               vedar,
  output logic               falta_rolha,
  output logic               erro_rolha,
  output logic [STOCK_W-1:0] estoque,
  output logic [STOCK_W-1:0] garrafas_vedadas
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PEDE   = 3'd1;
  localparam logic [2:0] S_ESPERA = 3'd2;
  localparam logic [2:0] S_VEDA   = 3'd3;
  localparam logic [2:0] S_LIBERA = 3'd4;
  localparam logic [2:0] S_FALTA  = 3'd5;
  localparam logic [2:0] S_ERRO   = 3'd6;

  localparam int CW = (CAP_CYCLES > 1) ? $clog2(CAP_CYCLES) : 1;
  localparam int SW = STOCK_W + 2;

  logic [2:0]         state, state_nxt;
  logic [CW-1:0]      cap_cnt;
  logic               add_prev;
  logic               add_rise;
  logic               consume;
  logic               timeout_hit;
  logic               stock_zero;
  logic [STOCK_W-1:0] stock, vedadas;
  logic [SW-1:0]      stock_sum;
  logic [STOCK_W-1:0] stock_nxt;

  assign add_rise   = add_rolha & ~add_prev;
  assign consume    = (state == S_ESPERA) & rolha_det;
  assign stock_zero = (stock == '0);

`ifdef VEDACAO_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_PEDE) begin
      wait_cnt <= '0;
    end else if ((state == S_ESPERA) && (wait_cnt != WW'(TIMEOUT_CYCLES))) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Terminal ESPERA cycle; rolha_det on this same cycle still wins.
  assign timeout_hit = (wait_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign erro_rolha  = (state == S_ERRO);
`else
  // Constant false: ESPERA waits for the stopper indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign erro_rolha  = 1'b0;
`endif

  always_comb begin
    stock_sum = {2'b00, stock};
    if (add_rise) stock_sum = stock_sum + SW'(ADD_QTY);
    if (consume)  stock_sum = stock_sum - SW'(1);
    stock_nxt = (stock_sum > SW'(STOCK_MAX)) ? STOCK_W'(STOCK_MAX) : stock_sum[STOCK_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_prev <= 1'b0;
      stock    <= '0;
      vedadas  <= '0;
      cap_cnt  <= '0;
    end else begin
      add_prev <= add_rolha;
      stock    <= stock_nxt;
      if (consume) begin
        cap_cnt <= CW'(CAP_CYCLES - 1);
      end else if ((state == S_VEDA) && (cap_cnt != '0)) begin
        cap_cnt <= cap_cnt - CW'(1);
      end
      if ((state == S_VEDA) && (cap_cnt == '0)) begin
        vedadas <= vedadas + STOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (garrafa_pos && garrafa_cheia) state_nxt = stock_zero ? S_FALTA : S_PEDE;
      end
      S_PEDE:   state_nxt = S_ESPERA;
      S_ESPERA: begin
        if (rolha_det)        state_nxt = S_VEDA;
        else if (timeout_hit) state_nxt = S_ERRO;
      end
      S_VEDA: begin
        if (cap_cnt == '0) state_nxt = S_LIBERA;
      end
      S_LIBERA: begin
        if (!garrafa_pos) state_nxt = S_IDLE;
      end
      S_FALTA: begin
        if (!stock_zero) state_nxt = S_PEDE;
      end
      S_ERRO:   state_nxt = S_ERRO;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    motor_esteira = 1'b0;
    pede_rolha    = 1'b0;
    vedar         = 1'b0;
    falta_rolha   = 1'b0;
    case (state)
      S_IDLE:   motor_esteira = 1'b1;
      S_LIBERA: motor_esteira = 1'b1;
      S_PEDE:   pede_rolha    = 1'b1;
      S_VEDA:   vedar         = 1'b1;
      S_FALTA:  falta_rolha   = 1'b1;
      default:  motor_esteira = 1'b0;
    endcase
  end

  assign estoque_ok       = (stock >= STOCK_W'(LOW_THRESH));
  assign estoque          = stock;
  assign garrafas_vedadas = vedadas;

endmodule

// File: tb/tb_controle_vedacao.sv
// Bench for controle_vedacao: directed vector table, hand-built corner sequences and
// random stimulus checked cycle by cycle against a phase-level model of the capping station.
module tb_controle_vedacao;
  localparam int STOCK_W        = 8;
  localparam int STOCK_MAX      = 20;
  localparam int ADD_QTY        = 5;
  localparam int LOW_THRESH     = 5;
  localparam int CAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic garrafa_pos = 1'b0, garrafa_cheia = 1'b0, add_rolha = 1'b0, rolha_det = 1'b0;
  logic estoque_ok, motor_esteira, pede_rolha, vedar, falta_rolha, erro_rolha;
  logic [STOCK_W-1:0] estoque, garrafas_vedadas;

  always #5 clk = ~clk;

  controle_vedacao #(
    .STOCK_W(STOCK_W), .STOCK_MAX(STOCK_MAX), .ADD_QTY(ADD_QTY), .LOW_THRESH(LOW_THRESH),
    .CAP_CYCLES(CAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .garrafa_pos(garrafa_pos), .garrafa_cheia(garrafa_cheia),
    .add_rolha(add_rolha), .rolha_det(rolha_det), .estoque_ok(estoque_ok),
    .motor_esteira(motor_esteira), .pede_rolha(pede_rolha), .vedar(vedar),
    .falta_rolha(falta_rolha), .erro_rolha(erro_rolha), .estoque(estoque),
    .garrafas_vedadas(garrafas_vedadas)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Station model: what the operator sees, not how the controller encodes it.
  typedef enum int {M_WAIT_BOTTLE, M_REQUEST, M_WAIT_STOPPER, M_CAPPING, M_RELEASE, M_NO_STOCK, M_FAULT} mphase_t;
  mphase_t m_phase;
  int m_stock, m_bottles, m_cap_left, m_wait;
  bit m_prev_add;

  function automatic void model_reset();
    m_phase = M_WAIT_BOTTLE; m_stock = 0; m_bottles = 0; m_cap_left = 0; m_wait = 0; m_prev_add = 0;
  endfunction

  function automatic void model_clock(bit p, bit c, bit a, bit d);
    bit rise;
    int used;
    rise = a && !m_prev_add;
    m_prev_add = a;
    used = 0;
    case (m_phase)
      M_WAIT_BOTTLE: if (p && c) m_phase = (m_stock > 0) ? M_REQUEST : M_NO_STOCK;
      M_REQUEST: begin m_phase = M_WAIT_STOPPER; m_wait = 0; end
      M_WAIT_STOPPER: begin
        if (d) begin
          used = 1; m_phase = M_CAPPING; m_cap_left = CAP_CYCLES;
        end else begin
          m_wait++;
`ifdef VEDACAO_TIMEOUT_EN
          if (m_wait >= TIMEOUT_CYCLES) m_phase = M_FAULT;
`endif
        end
      end
      M_CAPPING: begin
        m_cap_left--;
        if (m_cap_left == 0) begin
          m_phase = M_RELEASE;
          m_bottles = (m_bottles + 1) % (1 << STOCK_W);
        end
      end
      M_RELEASE:  if (!p) m_phase = M_WAIT_BOTTLE;
      M_NO_STOCK: if (m_stock > 0) m_phase = M_REQUEST;
      default:    m_phase = M_FAULT;
    endcase
    m_stock = m_stock + (rise ? ADD_QTY : 0) - used;
    if (m_stock > STOCK_MAX) m_stock = STOCK_MAX;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".motor"}, motor_esteira, (m_phase == M_WAIT_BOTTLE) || (m_phase == M_RELEASE));
    check({tag, ".pede"}, pede_rolha, m_phase == M_REQUEST);
    check({tag, ".vedar"}, vedar, m_phase == M_CAPPING);
    check({tag, ".falta"}, falta_rolha, m_phase == M_NO_STOCK);
    check({tag, ".erro"}, erro_rolha, m_phase == M_FAULT);
    check({tag, ".estoque"}, estoque, m_stock);
    check({tag, ".vedadas"}, garrafas_vedadas, m_bottles);
    check({tag, ".ok"}, estoque_ok, m_stock >= LOW_THRESH);
  endtask

  task automatic step(input string tag, input bit p, input bit c, input bit a, input bit d);
    garrafa_pos = p; garrafa_cheia = c; add_rolha = a; rolha_det = d;
    @(posedge clk);
    model_clock(p, c, a, d);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset();
    garrafa_pos = 0; garrafa_cheia = 0; add_rolha = 0; rolha_det = 0;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input string tag);
    step(tag, 0, 0, 1, 0); step(tag, 0, 0, 1, 0);
    step(tag, 0, 0, 0, 0); step(tag, 0, 0, 0, 0);
  endtask

  task automatic cap_bottle(input string tag, input bit add_at_det);
    step(tag, 1, 1, 0, 0);
    step(tag, 1, 1, 0, 0);
    step(tag, 1, 1, 0, 0);
    step(tag, 1, 1, add_at_det, 1);
    for (int k = 0; k < CAP_CYCLES; k++) step(tag, 1, 1, 0, 0);
    step(tag, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit p, c, a, d;
    bit motor, pede, ved, falta;
    int est, bot;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input bit p, c, a, d, input bit mo, pe, ve, fa, input int est, bot);
    tbl.push_back('{p, c, a, d, mo, pe, ve, fa, est, bot});
  endtask

  task automatic add_pulse_rows(input int est, input int bot);
    addv(0, 0, 1, 0, 1, 0, 0, 0, est, bot); addv(0, 0, 1, 0, 1, 0, 0, 0, est, bot);
    addv(0, 0, 0, 0, 1, 0, 0, 0, est, bot); addv(0, 0, 0, 0, 1, 0, 0, 0, est, bot);
  endtask

  initial begin
    // Vector table: first refill, one full capping with a mid-VEDA drop of garrafa_pos, then saturation.
    add_pulse_rows(5, 0);
    addv(1, 1, 0, 0, 0, 1, 0, 0, 5, 0);
    addv(1, 1, 0, 0, 0, 0, 0, 0, 5, 0);
    addv(1, 1, 0, 0, 0, 0, 0, 0, 5, 0);
    addv(1, 1, 0, 0, 0, 0, 0, 0, 5, 0);
    addv(1, 1, 0, 1, 0, 0, 1, 0, 4, 0);
    addv(0, 1, 0, 0, 0, 0, 1, 0, 4, 0);
    addv(1, 1, 0, 0, 0, 0, 1, 0, 4, 0);
    addv(1, 1, 0, 0, 0, 0, 1, 0, 4, 0);
    addv(1, 1, 0, 0, 1, 0, 0, 0, 4, 1);
    addv(1, 1, 0, 0, 1, 0, 0, 0, 4, 1);
    addv(1, 1, 0, 0, 1, 0, 0, 0, 4, 1);
    addv(0, 0, 0, 0, 1, 0, 0, 0, 4, 1);
    addv(1, 0, 0, 0, 1, 0, 0, 0, 4, 1);
    add_pulse_rows(9, 1);
    add_pulse_rows(14, 1);
    add_pulse_rows(19, 1);
    add_pulse_rows(20, 1);
    add_pulse_rows(20, 1);

    @(negedge clk);
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      garrafa_pos = tbl[i].p; garrafa_cheia = tbl[i].c; add_rolha = tbl[i].a; rolha_det = tbl[i].d;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d.motor", i), motor_esteira, tbl[i].motor);
      check($sformatf("vec%0d.pede", i), pede_rolha, tbl[i].pede);
      check($sformatf("vec%0d.vedar", i), vedar, tbl[i].ved);
      check($sformatf("vec%0d.falta", i), falta_rolha, tbl[i].falta);
      check($sformatf("vec%0d.erro", i), erro_rolha, 0);
      check($sformatf("vec%0d.estoque", i), estoque, tbl[i].est);
      check($sformatf("vec%0d.vedadas", i), garrafas_vedadas, tbl[i].bot);
      check($sformatf("vec%0d.ok", i), estoque_ok, tbl[i].est >= LOW_THRESH);
    end

    // Empty stock: alarm, refill, exit one cycle after the stock update.
    do_reset();
    step("falta", 1, 1, 0, 0);
    check("falta_alarm", falta_rolha, 1);
    step("falta", 1, 1, 0, 0);
    step("falta_add", 1, 1, 1, 0);
    check("falta_after_refill", falta_rolha, 1);
    check("falta_stock", estoque, ADD_QTY);
    step("falta_exit", 1, 1, 1, 0);
    check("falta_exit_pede", pede_rolha, 1);
    step("falta", 1, 1, 0, 0);
    step("falta", 1, 1, 0, 1);
    for (int k = 0; k < CAP_CYCLES; k++) step("falta", 1, 1, 0, 0);
    step("falta", 0, 0, 0, 0);
    check("falta_final_stock", estoque, ADD_QTY - 1);

    // Refill coinciding with the stopper consume: saturated and unsaturated.
    do_reset();
    for (int k = 0; k < 4; k++) pulse("fill20");
    cap_bottle("sat", 1'b1);
    check("coincide_saturated", estoque, 20);
    do_reset();
    pulse("fill5");
    cap_bottle("c1", 1'b0);
    cap_bottle("c2", 1'b0);
    check("stock_three", estoque, 3);
    cap_bottle("c3", 1'b1);
    check("coincide_from_three", estoque, 7);
    check("coincide_bottles", garrafas_vedadas, 3);

    // Asynchronous reset in the second VEDA cycle, then an unfilled bottle.
    do_reset();
    pulse("mr");
    step("mr", 1, 1, 0, 0);
    step("mr", 1, 1, 0, 0);
    step("mr", 1, 1, 0, 1);
    step("mr", 1, 1, 0, 0);
    check("mr_vedar_before", vedar, 1);
    #2 reset = 1'b1;
    #1;
    check("mr_vedar_now", vedar, 0);
    check("mr_motor_now", motor_esteira, 1);
    check("mr_estoque_now", estoque, 0);
    check("mr_vedadas_now", garrafas_vedadas, 0);
    model_reset();
    @(negedge clk);
    garrafa_pos = 0; garrafa_cheia = 0; add_rolha = 0; rolha_det = 0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step("unfilled", 1, 0, 0, 0);
    check("unfilled_no_pede", pede_rolha, 0);

`ifdef VEDACAO_TIMEOUT_EN
    do_reset();
    pulse("to");
    step("to", 1, 1, 0, 0);
    step("to", 1, 1, 0, 0);
    for (int k = 0; k < TIMEOUT_CYCLES; k++) step("to_wait", 1, 1, 0, 0);
    check("timeout_erro", erro_rolha, 1);
    for (int k = 0; k < 5; k++) step("to_hold", 0, 0, 1, 1);
    check("timeout_erro_held", erro_rolha, 1);
    do_reset();
    pulse("to2");
    step("to2", 1, 1, 0, 0);
    step("to2", 1, 1, 0, 0);
    for (int k = 0; k < TIMEOUT_CYCLES - 1; k++) step("to2_wait", 1, 1, 0, 0);
    step("to2_det", 1, 1, 0, 1);
    check("timeout_det_wins", vedar, 1);
    check("timeout_det_no_erro", erro_rolha, 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step("rand",
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/controle_vedacao.md
Name: controle_vedacao

Overview:
Capping-station controller that sits directly downstream of the stopper dispenser FSM.
- Keeps the stopper stock count and feeds the threshold flag back to the dispenser's stopper-available input.
- Adds stoppers on each add request.
- Runs the per-bottle sequence: stop conveyor, request stopper, wait for stopper at head, actuate capper, release bottle.
- Counts capped bottles.

Parameters:
STOCK_W, 8, width of stock and bottle counters
STOCK_MAX, 20, stock saturation ceiling
ADD_QTY, 5, stoppers added per add_rolha rising edge
LOW_THRESH, 5, estoque_ok asserted when stock >= LOW_THRESH
CAP_CYCLES, 4, clock cycles vedar stays high per bottle (>=1)
TIMEOUT_CYCLES, 64, max wait for rolha_det (macro build only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
garrafa_pos  in  1  bottle present at capping position
garrafa_cheia  in  1  bottle at position is filled
add_rolha  in  1  add request level from dispenser; rising edge = one refill
rolha_det  in  1  stopper detected at capping head
estoque_ok  out  1  stock >= LOW_THRESH
motor_esteira  out  1  conveyor run
pede_rolha  out  1  one-cycle stopper release pulse
vedar  out  1  capper actuator
falta_rolha  out  1  empty-stock alarm
erro_rolha  out  1  stopper timeout alarm
estoque  out  STOCK_W  current stock
garrafas_vedadas  out  STOCK_W  capped bottle count

Behaviour:
- Clock and reset: reset, asynchronous, active-high; clock clk. All state in flops on posedge clk / posedge reset.
- Reset values: state=IDLE; stock=0; garrafas_vedadas=0; add edge register=0.
  - Outputs after reset: motor_esteira=1, all other 1-bit outputs 0, estoque_ok=0.
- Outputs are Moore-decoded from state; estoque_ok is decoded from the stock register.
- Add detect: add_rolha is registered; rise = add_rolha & ~prev. On rise, stock = min(stock+ADD_QTY, STOCK_MAX).
- Consume: stock decrements by 1 on the ESPERA->VEDA transition.
  - Add and consume in the same cycle: stock = min(stock+ADD_QTY-1, STOCK_MAX).
  - Stock never underflows, since consume only happens with stock>0.
- garrafas_vedadas increments on VEDA->LIBERA and wraps modulo 2^STOCK_W.
- FSM states:
  - IDLE: motor=1.
    - garrafa_pos & garrafa_cheia & stock>0 -> PEDE.
    - garrafa_pos & garrafa_cheia & stock==0 -> FALTA.
    - An unfilled bottle is not capped; stay IDLE.
  - PEDE: motor=0, pede_rolha=1 for exactly 1 cycle -> ESPERA.
  - ESPERA: motor=0; rolha_det=1 -> VEDA, and the cap counter loads CAP_CYCLES-1.
  - VEDA: motor=0, vedar=1; counter decrements each cycle; at 0 -> LIBERA. vedar is high exactly CAP_CYCLES cycles.
  - LIBERA: motor=1; remain until garrafa_pos==0, then -> IDLE. The same bottle is never capped twice.
  - FALTA: motor=0, falta_rolha=1; stock>0 (from a refill) -> PEDE.
  - ERRO: motor=0, erro_rolha=1; exit only by reset. Reachable only with the macro.
  - Illegal encodings -> IDLE.
- Mid-sequence events:
  - garrafa_pos dropping during PEDE/ESPERA/VEDA is ignored; the sequence completes.
  - Reset mid-sequence returns to IDLE immediately (async), clears stock and counters, drops vedar the same instant.
- A refill during FALTA exits on the cycle after stock updates.

Optional Feature:
VEDACAO_TIMEOUT_EN
- Defined: a wait counter clears on PEDE->ESPERA and counts each ESPERA cycle. If TIMEOUT_CYCLES ESPERA cycles elapse without rolha_det -> ERRO. rolha_det arriving on the terminal cycle wins -> VEDA.
- Undefined: ESPERA waits indefinitely; ERRO is unreachable; erro_rolha is tied 0; no counter logic is built.

Test Plan:
- Reset, 3 add_rolha pulses (level high 2 cycles, low 2 cycles each) -> estoque 5, 10, 15; estoque_ok=1 from the first; a 5th pulse saturates at 20.
- stock=5, garrafa_pos=1 & cheia=1, rolha_det after 3 cycles -> pede_rolha 1 cycle, motor 0, vedar high 4 cycles, estoque=4, garrafas_vedadas=1; motor=1 in LIBERA until garrafa_pos=0.
- stock=0, filled bottle arrives -> falta_rolha=1, motor=0; add pulse -> estoque=5, then PEDE, full capping, estoque=4.
- stock=20, add rise coincides with ESPERA->VEDA -> estoque=20 (saturated); stock=3 same event -> estoque=7.
- Assert reset during VEDA (cycle 2) -> vedar=0 and motor=1 at once; estoque=0, garrafas_vedadas=0; unfilled bottle (cheia=0) afterwards -> stays IDLE, no pede_rolha.
- VEDACAO_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, rolha_det never asserted -> ERRO after 64 ESPERA cycles, erro_rolha=1 until reset; rolha_det on cycle 64 -> VEDA instead.
